// File: rtl/wave_sequencer.sv
// Double-buffered DDS segment sequencer: the host loads a shadow bank, a commit
// swaps it into the active bank, and segments of programmable length are timed.
module wave_sequencer #(
  parameter int unsigned NCH = 64,
  parameter int unsigned DW  = 16,
  parameter int unsigned TW  = 16,
  parameter int unsigned AW  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_wr,
  input  logic [1:0]        ld_field,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DW-1:0]     ld_data,
  input  logic [TW-1:0]     seg_len,
  input  logic              repeat_mode,
  input  logic              commit,
  input  logic              abort,
  output logic [NCH*DW-1:0] active_amps,
  output logic [NCH*DW-1:0] active_offsets,
  output logic [NCH*DW-1:0] active_phasewords,
  output logic              bank_reset,
  output logic              sample_en,
  output logic              seg_done,
  output logic              busy,
  output logic              pending,
  output logic [15:0]       seg_count
);

  localparam int unsigned BW = NCH * DW;
  localparam int unsigned IW = (BW > 1) ? $clog2(BW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t          state, state_d;
  logic [TW-1:0]   cnt, cnt_d;
  logic [TW-1:0]   len_q, len_d;
  logic [TW-1:0]   eff_len;
  logic            pending_d;
  logic            swap;
  logic            done_d;
  logic            wr_ok;
  logic [IW-1:0]   wr_base;
  logic [BW-1:0]   shadow_amps, shadow_offsets, shadow_phasewords;

  assign eff_len = (seg_len == '0) ? TW'(1) : seg_len;
  assign wr_ok   = ld_wr && (ld_field != 2'd3) && (32'(ld_addr) < NCH);
  assign wr_base = IW'(32'(ld_addr) * DW);

  // Host writes into the shadow bank; a swap in the same cycle sees the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_amps       <= '0;
      shadow_offsets    <= '0;
      shadow_phasewords <= '0;
    end else if (wr_ok) begin
      case (ld_field)
        2'd0:    shadow_amps[wr_base +: DW]       <= ld_data;
        2'd1:    shadow_offsets[wr_base +: DW]    <= ld_data;
        default: shadow_phasewords[wr_base +: DW] <= ld_data;
      endcase
    end
  end

  // Active bank takes the shadow contents on every swap.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_amps       <= '0;
      active_offsets    <= '0;
      active_phasewords <= '0;
    end else if (swap) begin
      active_amps       <= shadow_amps;
      active_offsets    <= shadow_offsets;
      active_phasewords <= shadow_phasewords;
    end
  end

  // State register plus segment timer and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      len_q      <= '0;
      pending    <= 1'b0;
      seg_count  <= '0;
      bank_reset <= 1'b0;
      sample_en  <= 1'b0;
      seg_done   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      len_q      <= len_d;
      pending    <= pending_d;
      bank_reset <= swap;
      sample_en  <= (state_d == RUN);
      busy       <= (state_d == RUN);
      seg_done   <= done_d;
      if (done_d) seg_count <= seg_count + 16'd1;
    end
  end

  // Next-state logic: commits, segment boundaries and abort.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    len_d     = len_q;
    pending_d = pending;
    swap      = 1'b0;
    done_d    = 1'b0;
    if (abort) begin
      state_d   = IDLE;
      pending_d = 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (commit) begin
            swap    = 1'b1;
            len_d   = eff_len;
            cnt_d   = eff_len - TW'(1);
            state_d = RUN;
          end
        end
        RUN: begin
          if (commit) len_d = eff_len;
          if (cnt == '0) begin
            done_d = 1'b1;
            if (pending || commit) begin
              // A commit in the last cycle joins the queued swap at this boundary.
              swap      = 1'b1;
              pending_d = 1'b0;
              cnt_d     = (commit ? eff_len : len_q) - TW'(1);
            end else if (repeat_mode) begin
              cnt_d = len_q - TW'(1);
            end else begin
              state_d = HOLD;
            end
          end else begin
            cnt_d = cnt - TW'(1);
            if (commit) pending_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed self-checking bench for wave_sequencer (64- and 48-channel instances).
module tb_wave_sequencer;

  localparam int unsigned NCH = 64;
  localparam int unsigned N48 = 48;
  localparam int unsigned DW  = 16;
  localparam int unsigned TW  = 16;
  localparam int unsigned AW  = 6;

  logic clk = 1'b0;
  logic reset, ld_wr, repeat_mode, commit, abort;
  logic [1:0]    ld_field;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [TW-1:0] seg_len;

  logic [NCH*DW-1:0] amps, offs, pws;
  logic bank_reset, sample_en, seg_done, busy, pending;
  logic [15:0] seg_count;

  logic [N48*DW-1:0] amps_b, offs_b, pws_b;
  logic bank_reset_b, sample_en_b, seg_done_b, busy_b, pending_b;
  logic [15:0] seg_count_b;

  logic [DW-1:0] sh [3][NCH];
  logic [DW-1:0] act [3][NCH];
  logic [DW-1:0] sh_b [3][N48];
  logic [DW-1:0] act_b [3][N48];

  int n_checks = 0;
  int n_fail = 0;
  int n_se, n_br, n_sd;

  always #5 clk = ~clk;

  wave_sequencer #(.NCH(NCH), .DW(DW), .TW(TW), .AW(AW)) u_dut (
    .clk(clk), .reset(reset), .ld_wr(ld_wr), .ld_field(ld_field), .ld_addr(ld_addr),
    .ld_data(ld_data), .seg_len(seg_len), .repeat_mode(repeat_mode), .commit(commit),
    .abort(abort), .active_amps(amps), .active_offsets(offs), .active_phasewords(pws),
    .bank_reset(bank_reset), .sample_en(sample_en), .seg_done(seg_done), .busy(busy),
    .pending(pending), .seg_count(seg_count)
  );

  wave_sequencer #(.NCH(N48), .DW(DW), .TW(TW), .AW(AW)) u_dut48 (
    .clk(clk), .reset(reset), .ld_wr(ld_wr), .ld_field(ld_field), .ld_addr(ld_addr),
    .ld_data(ld_data), .seg_len(seg_len), .repeat_mode(repeat_mode), .commit(commit),
    .abort(abort), .active_amps(amps_b), .active_offsets(offs_b), .active_phasewords(pws_b),
    .bank_reset(bank_reset_b), .sample_en(sample_en_b), .seg_done(seg_done_b), .busy(busy_b),
    .pending(pending_b), .seg_count(seg_count_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int field, input int addr, input int data);
    ld_wr    = 1'b1;
    ld_field = 2'(field);
    ld_addr  = AW'(addr);
    ld_data  = DW'(data);
    if (field < 3) begin
      if (addr < int'(NCH)) sh[field][addr] = DW'(data);
      if (addr < int'(N48)) sh_b[field][addr] = DW'(data);
    end
    tick();
    ld_wr = 1'b0;
  endtask

  task automatic do_swap();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < int'(NCH); i++) act[f][i] = sh[f][i];
      for (int i = 0; i < int'(N48); i++) act_b[f][i] = sh_b[f][i];
    end
  endtask

  task automatic check_banks(input string tag);
    for (int i = 0; i < int'(NCH); i++) begin
      check($sformatf("%s amp[%0d]", tag, i), 64'(amps[i*DW +: DW]), 64'(act[0][i]));
      check($sformatf("%s off[%0d]", tag, i), 64'(offs[i*DW +: DW]), 64'(act[1][i]));
      check($sformatf("%s pw[%0d]", tag, i), 64'(pws[i*DW +: DW]), 64'(act[2][i]));
    end
    for (int i = 0; i < int'(N48); i++) begin
      check($sformatf("%s amp48[%0d]", tag, i), 64'(amps_b[i*DW +: DW]), 64'(act_b[0][i]));
      check($sformatf("%s off48[%0d]", tag, i), 64'(offs_b[i*DW +: DW]), 64'(act_b[1][i]));
      check($sformatf("%s pw48[%0d]", tag, i), 64'(pws_b[i*DW +: DW]), 64'(act_b[2][i]));
    end
  endtask

  task automatic run_cycles(input int n);
    n_se = 0; n_br = 0; n_sd = 0;
    repeat (n) begin
      n_se += int'(sample_en);
      n_br += int'(bank_reset);
      n_sd += int'(seg_done);
      tick();
    end
  endtask

  initial begin
    int guard;
    reset = 1'b1; ld_wr = 1'b0; ld_field = '0; ld_addr = '0; ld_data = '0;
    seg_len = '0; repeat_mode = 1'b0; commit = 1'b0; abort = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < int'(NCH); i++) begin sh[f][i] = '0; act[f][i] = '0; end
      for (int i = 0; i < int'(N48); i++) begin sh_b[f][i] = '0; act_b[f][i] = '0; end
    end
    repeat (3) tick();
    check("rst sample_en", 64'(sample_en), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst bank_reset", 64'(bank_reset), 64'd0);
    check("rst seg_done", 64'(seg_done), 64'd0);
    check("rst pending", 64'(pending), 64'd0);
    check("rst seg_count", 64'(seg_count), 64'd0);
    check_banks("rst");
    reset = 1'b0;
    tick();

    // 1: one-shot 4-cycle segment
    write_word(0, 5, 16'h1234);
    write_word(2, 63, 16'hFFFF);
    seg_len = 16'd4; repeat_mode = 1'b0; commit = 1'b1;
    tick(); commit = 1'b0; do_swap();
    check("t1 bank_reset", 64'(bank_reset), 64'd1);
    check("t1 bank_reset48", 64'(bank_reset_b), 64'd1);
    check_banks("t1");
    run_cycles(6);
    check("t1 sample cycles", 64'(n_se), 64'd4);
    check("t1 bank_reset count", 64'(n_br), 64'd1);
    check("t1 seg_done count", 64'(n_sd), 64'd1);
    check("t1 seg_count", 64'(seg_count), 64'd1);
    check("t1 busy", 64'(busy), 64'd0);

    // 2: ignored writes (field 3, address beyond 48 channels)
    write_word(3, 7, 16'hAAAA);
    write_word(0, 50, 16'hBBBB);
    seg_len = 16'd1; commit = 1'b1;
    tick(); commit = 1'b0; do_swap();
    check_banks("t2");
    run_cycles(3);
    check("t2 seg_count", 64'(seg_count), 64'd2);
    check("t2 seg_count48", 64'(seg_count_b), 64'd2);

    // 3: auto-repeat, ten 3-cycle segments
    seg_len = 16'd3; repeat_mode = 1'b1; commit = 1'b1;
    tick(); commit = 1'b0; do_swap();
    run_cycles(27);
    repeat_mode = 1'b0;
    begin
      int se0, br0, sd0;
      se0 = n_se; br0 = n_br; sd0 = n_sd;
      run_cycles(3);
      check("t3 sample cycles", 64'(se0 + n_se), 64'd30);
      check("t3 bank_reset count", 64'(br0 + n_br), 64'd1);
      check("t3 seg_done count", 64'(sd0 + n_sd), 64'd9);
    end
    check("t3 final seg_done", 64'(seg_done), 64'd1);
    check("t3 sample_en off", 64'(sample_en), 64'd0);
    check("t3 seg_count", 64'(seg_count), 64'd12);
    check("t3 seg_count48", 64'(seg_count_b), 64'd12);

    // 4: commit mid-RUN queues a seamless swap
    seg_len = 16'd4; repeat_mode = 1'b1; commit = 1'b1;
    tick(); commit = 1'b0; do_swap();
    write_word(0, 5, 16'h5555);
    seg_len = 16'd5; commit = 1'b1;
    tick(); commit = 1'b0; seg_len = 16'd9;
    check("t4 pending", 64'(pending), 64'd1);
    check("t4 no early bank_reset", 64'(bank_reset), 64'd0);
    check_banks("t4 pre");
    tick();
    check("t4 pending last cycle", 64'(pending), 64'd1);
    check("t4 sample_en last cycle", 64'(sample_en), 64'd1);
    tick(); do_swap();
    check("t4 bank_reset at boundary", 64'(bank_reset), 64'd1);
    check("t4 seg_done at boundary", 64'(seg_done), 64'd1);
    check("t4 pending cleared", 64'(pending), 64'd0);
    check("t4 no sample gap", 64'(sample_en), 64'd1);
    check_banks("t4 post");
    repeat_mode = 1'b0;
    run_cycles(6);
    check("t4 new seg cycles", 64'(n_se), 64'd5);
    check("t4 bank_reset count", 64'(n_br), 64'd1);
    check("t4 seg_done count", 64'(n_sd), 64'd2);
    check("t4 seg_count", 64'(seg_count), 64'd14);

    // 5: abort with commit in the 2nd cycle of a 100-cycle segment
    seg_len = 16'd100; commit = 1'b1;
    tick(); commit = 1'b0; do_swap();
    write_word(0, 5, 16'h7777);
    abort = 1'b1; commit = 1'b1;
    tick(); abort = 1'b0; commit = 1'b0;
    check("t5 busy", 64'(busy), 64'd0);
    check("t5 sample_en", 64'(sample_en), 64'd0);
    check("t5 pending", 64'(pending), 64'd0);
    check("t5 bank_reset", 64'(bank_reset), 64'd0);
    check("t5 seg_done", 64'(seg_done), 64'd0);
    check_banks("t5");
    run_cycles(3);
    check("t5 idle sample cycles", 64'(n_se), 64'd0);
    check("t5 idle seg_done", 64'(n_sd), 64'd0);
    check("t5 seg_count", 64'(seg_count), 64'd14);

    // 6: zero length means one cycle; seg_count wraps
    seg_len = 16'd0; commit = 1'b1;
    tick(); commit = 1'b0; do_swap();
    check("t6 bank_reset", 64'(bank_reset), 64'd1);
    check_banks("t6");
    run_cycles(3);
    check("t6 sample cycles", 64'(n_se), 64'd1);
    check("t6 seg_done count", 64'(n_sd), 64'd1);
    check("t6 seg_count", 64'(seg_count), 64'd15);
    repeat_mode = 1'b1; commit = 1'b1;
    tick(); commit = 1'b0;
    guard = 0;
    while (seg_count !== 16'hFFFF && guard < 70000) begin
      tick();
      guard++;
    end
    check("t6 reach 0xFFFF", 64'(guard < 70000), 64'd1);
    check("t6 running at 0xFFFF", 64'(sample_en), 64'd1);
    repeat_mode = 1'b0;
    tick();
    check("t6 wrap seg_count", 64'(seg_count), 64'd0);
    check("t6 wrap seg_done", 64'(seg_done), 64'd1);
    check("t6 stop after wrap", 64'(sample_en), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
